// File: rtl/spi_command_decoder_pkg.sv
// Shared types for the SPI command decoder: opcode and FSM encodings plus the
// frame-length helper used by the collector.
package spi_command_decoder_pkg;

    typedef enum logic [7:0] {
        WRITE          = 8'h01,
        READ           = 8'h02,
        BIND_INTERRUPT = 8'h03,
        BIND_ADDRESS   = 8'h04,
        TRANSFER       = 8'h05,
        REPEAT         = 8'h06
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2
    } state_t;

    // Opcodes that open a multi-byte frame (as opposed to the single-byte TX controls).
    function automatic logic is_long_opcode(input logic [7:0] op);
        return (op == WRITE) || (op == READ) || (op == BIND_INTERRUPT) || (op == BIND_ADDRESS);
    endfunction

    function automatic int unsigned frame_len(input logic [7:0] op,
                                              input int unsigned addr_bytes,
                                              input int unsigned val_bytes);
        case (op)
            WRITE:                               return 1 + addr_bytes + val_bytes;
            READ, BIND_INTERRUPT, BIND_ADDRESS:  return 1 + addr_bytes;
            default:                             return 0;
        endcase
    endfunction

endpackage

// File: rtl/spi_command_decoder_if.sv
// Bundle between the SPI byte side / core side and the command decoder.
// spi_rx_valid, cmd_valid and error are single-cycle strobes with no back-pressure:
// data beside a strobe is valid only in the cycle the strobe is high, and is never held off.
interface spi_command_decoder_if #(
    parameter int unsigned INSTRUCTION_WIDTH = 8,
    parameter int unsigned ADDRESS_WIDTH     = 24,
    parameter int unsigned VALUE_WIDTH       = 32
);
    logic                         spi_rx_valid;
    logic [7:0]                   spi_rx_byte;
    logic [VALUE_WIDTH-1:0]       value_from_core;
    logic [INSTRUCTION_WIDTH-1:0] instruction_bus;
    logic [ADDRESS_WIDTH-1:0]     address_bus;
    logic [VALUE_WIDTH-1:0]       value_bus;
    logic                         cmd_valid;
    logic [7:0]                   spi_tx_byte;
    logic                         error;

    modport master (
        output spi_rx_valid, spi_rx_byte, value_from_core,
        input  instruction_bus, address_bus, value_bus, cmd_valid, spi_tx_byte, error
    );

    modport slave (
        input  spi_rx_valid, spi_rx_byte, value_from_core,
        output instruction_bus, address_bus, value_bus, cmd_valid, spi_tx_byte, error
    );
endinterface

// File: rtl/spi_command_decoder_tx_word_serialiser.sv
// Holds a shadow copy of the core read-back word and hands it out one byte per
// advance, MSB first, so a multi-byte read never mixes two different core words.
module tx_word_serialiser #(
    parameter int unsigned VALUE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   latch_i,
    input  logic                   advance_i,
    input  logic                   rewind_i,
    input  logic [VALUE_WIDTH-1:0] word_i,
    output logic                   ptr_zero_o,
    output logic [7:0]             tx_byte_o
);
    localparam int unsigned VAL_BYTES = VALUE_WIDTH / 8;
    localparam int unsigned PTR_W     = (VAL_BYTES > 1) ? $clog2(VAL_BYTES) : 1;

    logic [VALUE_WIDTH-1:0] shadow_q, shadow_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [7:0]             tx_q, tx_d;
    logic [VALUE_WIDTH-1:0] shifted;

    always_comb begin
        shadow_d = latch_i ? word_i : shadow_q;
        // Byte ptr of the word ends up in the top byte after shifting left by ptr bytes.
        shifted  = shadow_d << {ptr_q, 3'b000};
        ptr_d    = ptr_q;
        tx_d     = tx_q;
        if (rewind_i) begin
            ptr_d = '0;
        end else if (advance_i) begin
            tx_d  = shifted[VALUE_WIDTH-1 -: 8];
            ptr_d = (ptr_q == PTR_W'(VAL_BYTES - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            ptr_q    <= '0;
            tx_q     <= '0;
        end else begin
            shadow_q <= shadow_d;
            ptr_q    <= ptr_d;
            tx_q     <= tx_d;
        end
    end

    assign ptr_zero_o = (ptr_q == '0);
    assign tx_byte_o  = tx_q;
endmodule

// File: rtl/spi_command_decoder.sv
// Turns the SPI slave byte stream into opcode/address/value command strobes and
// drives read-back bytes for TRANSFER; flags unknown opcodes and stalled frames.
module spi_command_decoder
    import spi_command_decoder_pkg::*;
#(
    parameter int unsigned INSTRUCTION_WIDTH = 8,
    parameter int unsigned ADDRESS_WIDTH     = 24,
    parameter int unsigned VALUE_WIDTH       = 32,
    parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_command_decoder_if.slave bus,
    output state_t               state_o
);
    localparam int unsigned ADDR_BYTES = ADDRESS_WIDTH / 8;
    localparam int unsigned VAL_BYTES  = VALUE_WIDTH / 8;
    localparam int unsigned FIELD_W    = ADDRESS_WIDTH + VALUE_WIDTH;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned TMR_W      = $clog2(TIMEOUT_CYCLES);

    state_t                       state_q, state_d;
    logic [7:0]                   opcode_q, opcode_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [FIELD_W-1:0]           field_q, field_d;
    logic [TMR_W-1:0]             timer_q, timer_d;

    logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
    logic [ADDRESS_WIDTH-1:0]     addr_q, addr_d;
    logic [VALUE_WIDTH-1:0]       value_q, value_d;
    logic                         cmd_valid_q, cmd_valid_d;
    logic                         error_q, error_d;

    logic cmd_slot;
    logic transfer;
    logic rewind;
    logic bad_opcode;
    logic timeout;
    logic ptr_zero;

    // ISSUE lasts one cycle but still accepts a byte exactly as IDLE does.
    assign cmd_slot   = (state_q != COLLECT) && bus.spi_rx_valid;
    assign transfer   = cmd_slot && (bus.spi_rx_byte == TRANSFER);
    assign rewind     = cmd_slot && (bus.spi_rx_byte == REPEAT);
    assign bad_opcode = cmd_slot && !is_long_opcode(bus.spi_rx_byte) && !transfer && !rewind;
    assign timeout    = (state_q == COLLECT) && !bus.spi_rx_valid &&
                        (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            opcode_q    <= '0;
            count_q     <= '0;
            field_q     <= '0;
            timer_q     <= '0;
            instr_q     <= '0;
            addr_q      <= '0;
            value_q     <= '0;
            cmd_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            count_q     <= count_d;
            field_q     <= field_d;
            timer_q     <= timer_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            value_q     <= value_d;
            cmd_valid_q <= cmd_valid_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        count_d  = count_q;
        field_d  = field_q;
        timer_d  = timer_q;
        case (state_q)
            IDLE, ISSUE: begin
                state_d = IDLE;
                if (cmd_slot && is_long_opcode(bus.spi_rx_byte)) begin
                    opcode_d = bus.spi_rx_byte;
                    count_d  = CNT_W'(1);
                    field_d  = '0;
                    timer_d  = '0;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.spi_rx_valid) begin
                    // A byte on the expiry cycle still counts and restarts the timer.
                    field_d = {field_q[FIELD_W-9:0], bus.spi_rx_byte};
                    count_d = count_q + CNT_W'(1);
                    timer_d = '0;
                    if (32'(count_q) + 32'd1 == frame_len(opcode_q, ADDR_BYTES, VAL_BYTES))
                        state_d = ISSUE;
                end else if (timeout) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_d     = instr_q;
        addr_d      = addr_q;
        value_d     = value_q;
        cmd_valid_d = 1'b0;
        error_d     = bad_opcode || timeout;
        if (state_q == ISSUE) begin
            instr_d     = opcode_q;
            cmd_valid_d = 1'b1;
            // Short frames leave the address in the low bits of the field register.
            if (opcode_q == WRITE) begin
                addr_d  = field_q[VALUE_WIDTH +: ADDRESS_WIDTH];
                value_d = field_q[VALUE_WIDTH-1:0];
            end else begin
                addr_d  = field_q[ADDRESS_WIDTH-1:0];
                value_d = '0;
            end
        end
    end

    tx_word_serialiser #(
        .VALUE_WIDTH (VALUE_WIDTH)
    ) u_tx (
        .clk        (clk),
        .rst        (rst),
        .latch_i    (transfer && ptr_zero),
        .advance_i  (transfer),
        .rewind_i   (rewind),
        .word_i     (bus.value_from_core),
        .ptr_zero_o (ptr_zero),
        .tx_byte_o  (bus.spi_tx_byte)
    );

    assign bus.instruction_bus = instr_q;
    assign bus.address_bus     = addr_q;
    assign bus.value_bus       = value_q;
    assign bus.cmd_valid       = cmd_valid_q;
    assign bus.error           = error_q;
    assign state_o             = state_q;
endmodule

// File: tb/tb_spi_command_decoder.sv
// Bench for spi_command_decoder: a 24/32-bit instance for most cases and a
// 16/64-bit instance to exercise the width-derived frame lengths.
module tb_spi_command_decoder;
    import spi_command_decoder_pkg::*;

    localparam int unsigned T1 = 1024;
    localparam int unsigned T2 = 16;

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        logic [31:0] val;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t state1, state2;

    int total = 0;
    int bad   = 0;
    int err1  = 0;
    int err2  = 0;

    logic [63:0] exp_q[$];
    logic [87:0] exp2_q[$];
    logic [63:0] last1;
    logic [63:0] pop1;
    logic [87:0] pop2;

    always #5 clk = ~clk;

    spi_command_decoder_if #(.ADDRESS_WIDTH(24), .VALUE_WIDTH(32)) bus1 ();
    spi_command_decoder_if #(.ADDRESS_WIDTH(16), .VALUE_WIDTH(64)) bus2 ();

    spi_command_decoder #(
        .INSTRUCTION_WIDTH (8), .ADDRESS_WIDTH (24), .VALUE_WIDTH (32), .TIMEOUT_CYCLES (T1)
    ) u_dut1 (.clk(clk), .rst(rst), .bus(bus1), .state_o(state1));

    spi_command_decoder #(
        .INSTRUCTION_WIDTH (8), .ADDRESS_WIDTH (16), .VALUE_WIDTH (64), .TIMEOUT_CYCLES (T2)
    ) u_dut2 (.clk(clk), .rst(rst), .bus(bus2), .state_o(state2));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every cmd_valid pops one expected {opcode, address, value} record.
    always @(negedge clk) begin
        if (bus1.error === 1'b1) err1++;
        if (bus2.error === 1'b1) err2++;
        if (bus1.cmd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_cmd1: got addr %0h expected no command", bus1.address_bus);
            end else begin
                pop1 = exp_q.pop_front();
                check("cmd1", {bus1.instruction_bus, bus1.address_bus, bus1.value_bus}, pop1);
            end
        end
        if (bus2.cmd_valid === 1'b1) begin
            if (exp2_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_cmd2: got addr %0h expected no command", bus2.address_bus);
            end else begin
                pop2 = exp2_q.pop_front();
                check("cmd2", {bus2.instruction_bus, bus2.address_bus, bus2.value_bus}, pop2);
            end
        end
    end

    task automatic gap(input int gap_max);
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
    endtask

    task automatic send1(input logic [7:0] b);
        bus1.spi_rx_valid = 1'b1;
        bus1.spi_rx_byte  = b;
        @(negedge clk);
        bus1.spi_rx_valid = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        bus2.spi_rx_valid = 1'b1;
        bus2.spi_rx_byte  = b;
        @(negedge clk);
        bus2.spi_rx_valid = 1'b0;
    endtask

    task automatic send_frame1(input logic [7:0] op, input logic [23:0] a,
                               input logic [31:0] v, input int gap_max);
        logic [63:0] e;
        e = {op, a, (op == WRITE) ? v : 32'h0};
        exp_q.push_back(e);
        last1 = e;
        send1(op);
        for (int i = 0; i < 3; i++) begin gap(gap_max); send1(a[(2-i)*8 +: 8]); end
        if (op == WRITE)
            for (int i = 0; i < 4; i++) begin gap(gap_max); send1(v[(3-i)*8 +: 8]); end
    endtask

    task automatic send_frame2(input logic [7:0] op, input logic [15:0] a, input logic [63:0] v);
        exp2_q.push_back({op, a, (op == WRITE) ? v : 64'h0});
        send2(op);
        for (int i = 0; i < 2; i++) send2(a[(1-i)*8 +: 8]);
        if (op == WRITE)
            for (int i = 0; i < 8; i++) send2(v[(7-i)*8 +: 8]);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < 8) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size() + exp2_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[7];
        logic [7:0]  ops[4];
        logic [7:0]  tx_before;
        logic [31:0] w;
        logic [63:0] w2;
        int          e0;

        vecs[0] = '{WRITE,          24'h123456, 32'hDEADBEEF};
        vecs[1] = '{READ,           24'h00ABCD, 32'hFFFFFFFF};
        vecs[2] = '{BIND_INTERRUPT, 24'h000007, 32'h11111111};
        vecs[3] = '{BIND_ADDRESS,   24'hFFFFFF, 32'h0};
        vecs[4] = '{WRITE,          24'h050605, 32'h05060506};
        vecs[5] = '{WRITE,          24'h000000, 32'h00000000};
        vecs[6] = '{WRITE,          24'hFFFFFF, 32'hFFFFFFFF};
        ops[0] = WRITE; ops[1] = READ; ops[2] = BIND_INTERRUPT; ops[3] = BIND_ADDRESS;

        bus1.spi_rx_valid = 1'b0; bus1.spi_rx_byte = '0; bus1.value_from_core = '0;
        bus2.spi_rx_valid = 1'b0; bus2.spi_rx_byte = '0; bus2.value_from_core = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_instr", bus1.instruction_bus, 0);
        check("rst_addr", bus1.address_bus, 0);
        check("rst_value", bus1.value_bus, 0);
        check("rst_cmd", bus1.cmd_valid, 0);
        check("rst_tx", bus1.spi_tx_byte, 0);
        check("rst_err", bus1.error, 0);
        check("rst_state", state1, IDLE);
        check("rst_addr2", bus2.address_bus, 0);
        rst = 1'b0;
        @(negedge clk);

        // WRITE back-to-back with exact strobe timing
        send_frame1(WRITE, 24'h123456, 32'hDEADBEEF, 0);
        check("latency_early", bus1.cmd_valid, 0);
        @(negedge clk);
        check("latency_cmd", bus1.cmd_valid, 1);
        @(negedge clk);
        check("cmd_one_cycle", bus1.cmd_valid, 0);
        check("addr_hold", bus1.address_bus, 24'h123456);
        check("value_hold", bus1.value_bus, 32'hDEADBEEF);
        drain("drain_write");

        // Tear-free read-back, REPEAT and wrap
        e0 = err1;
        bus1.value_from_core = 32'hCAFEF00D;
        send1(TRANSFER); check("tx_b0", bus1.spi_tx_byte, 8'hCA);
        bus1.value_from_core = 32'h12345678;
        send1(TRANSFER); check("tx_b1", bus1.spi_tx_byte, 8'hFE);
        send1(TRANSFER); check("tx_b2", bus1.spi_tx_byte, 8'hF0);
        send1(TRANSFER); check("tx_b3", bus1.spi_tx_byte, 8'h0D);
        send1(REPEAT);   check("tx_repeat_hold", bus1.spi_tx_byte, 8'h0D);
        bus1.value_from_core = 32'hCAFEF00D;
        send1(TRANSFER); check("tx_after_repeat", bus1.spi_tx_byte, 8'hCA);
        bus1.value_from_core = 32'h9A000000;
        send1(TRANSFER); check("tx_shadow_b1", bus1.spi_tx_byte, 8'hFE);
        send1(TRANSFER); send1(TRANSFER);
        send1(TRANSFER); check("tx_wrap_relatch", bus1.spi_tx_byte, 8'h9A);
        send1(REPEAT);
        @(negedge clk);
        check("tx_no_err", err1 - e0, 0);

        // Unknown opcode and TRANSFER/REPEAT used as payload
        e0 = err1;
        send1(8'hFF);
        @(negedge clk);
        check("bad_op_err", err1 - e0, 1);
        check("bad_op_state", state1, IDLE);
        tx_before = bus1.spi_tx_byte;
        send_frame1(WRITE, 24'h050605, 32'h05060506, 0);
        drain("drain_payload");
        check("payload_tx_hold", bus1.spi_tx_byte, tx_before);

        // Table vectors then random frames with random byte gaps
        for (int i = 0; i < 7; i++) begin
            send_frame1(vecs[i].op, vecs[i].addr, vecs[i].val, 3);
            drain("drain_vec");
        end
        for (int i = 0; i < 6; i++) begin
            send_frame1(ops[$urandom_range(0, 3)], 24'($urandom), $urandom, 3);
            drain("drain_rand");
        end

        // Inter-byte timeout drops the frame and leaves the buses alone
        e0 = err1;
        send1(WRITE); send1(8'h11); send1(8'h22);
        repeat (T1 - 1) @(negedge clk);
        check("timeout_not_early", err1 - e0, 0);
        check("timeout_still_collect", state1, COLLECT);
        repeat (2) @(negedge clk);
        check("timeout_err", err1 - e0, 1);
        check("timeout_state", state1, IDLE);
        check("timeout_bus_hold", {bus1.instruction_bus, bus1.address_bus, bus1.value_bus}, last1);
        send_frame1(READ, 24'h00ABCD, 32'h0, 1);
        drain("drain_after_timeout");

        // Byte arriving on the expiry cycle keeps the frame alive
        e0 = err1;
        exp_q.push_back({8'(READ), 24'hABCDEF, 32'h0});
        send1(READ);
        repeat (T1 - 1) @(negedge clk);
        send1(8'hAB); send1(8'hCD); send1(8'hEF);
        drain("drain_byte_wins");
        check("byte_wins_no_err", err1 - e0, 0);

        // Reset in the middle of a WRITE
        send1(WRITE); send1(8'h01); send1(8'h02);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_instr", bus1.instruction_bus, 0);
        check("midrst_addr", bus1.address_bus, 0);
        check("midrst_value", bus1.value_bus, 0);
        check("midrst_tx", bus1.spi_tx_byte, 0);
        check("midrst_state", state1, IDLE);
        repeat (4) @(negedge clk);
        send_frame1(WRITE, 24'hA5A5A5, 32'h5A5A5A5A, 1);
        drain("drain_after_rst");

        // Wide-value / narrow-address instance
        send_frame2(WRITE, 16'h1234, 64'hDEADBEEF0BADF00D);
        drain("drain2_write");
        send_frame2(READ, 16'hABCD, 64'h0);
        drain("drain2_read");
        w2 = 64'h0123456789ABCDEF;
        bus2.value_from_core = w2;
        for (int i = 0; i < 8; i++) begin
            send2(TRANSFER);
            bus2.value_from_core = 64'($urandom);
            check("tx2_byte", bus2.spi_tx_byte, w2[(7-i)*8 +: 8]);
        end
        e0 = err2;
        send2(WRITE); send2(8'h77);
        repeat (T2 + 2) @(negedge clk);
        check("timeout2_err", err2 - e0, 1);
        check("timeout2_state", state2, IDLE);

        w = 32'(exp_q.size() + exp2_q.size());
        check("queues_empty", w, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
